// File: rtl/seg_conv_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_conv_sched_if
// Description : Requester and converter handshake bundle for seg_conv_sched.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_conv_sched_if;
    logic        req_a_valid;
    logic [13:0] req_a_num;
    logic        req_a_err;
    logic        req_a_ack;
    logic        req_b_valid;
    logic [13:0] req_b_num;
    logic        req_b_err;
    logic        req_b_ack;
    logic [13:0] conv_num;
    logic        conv_start;
    logic        conv_error;
    logic        conv_done;
    logic [31:0] conv_digits;

    // Scheduler side
    modport master (
        input  req_a_valid, req_a_num, req_a_err,
        input  req_b_valid, req_b_num, req_b_err,
        input  conv_done, conv_digits,
        output req_a_ack, req_b_ack,
        output conv_num, conv_start, conv_error
    );

    // Requester / converter side
    modport slave (
        output req_a_valid, req_a_num, req_a_err,
        output req_b_valid, req_b_num, req_b_err,
        output conv_done, conv_digits,
        input  req_a_ack, req_b_ack,
        input  conv_num, conv_start, conv_error
    );
endinterface
`default_nettype wire

// File: rtl/seg_conv_sched.sv
`default_nettype none
// ============================================================================
// Module      : seg_conv_sched
// Description : Round-robin sequencer for a shared 7-segment converter plus a
//               4-digit multiplexed display. Optional leading-zero blanking is
//               enabled by defining BLANK_LEADING_ZERO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_conv_sched #(
    parameter int SCAN_DIV = 50000,
    parameter int TIMEOUT  = 64
) (
    input  wire logic              clk,
    input  wire logic              rst,
    seg_conv_sched_if.master       bus,
    output logic [7:0]             seg,
    output logic [3:0]             an,
    output logic                   busy
);
    localparam int C_WAIT_W = $clog2(TIMEOUT);
    localparam int C_SCAN_W = $clog2(SCAN_DIV);
    localparam logic [C_WAIT_W-1:0] C_WAIT_LAST = C_WAIT_W'(TIMEOUT - 1);
    localparam logic [C_SCAN_W-1:0] C_SCAN_LAST = C_SCAN_W'(SCAN_DIV - 1);
    localparam logic [31:0] C_ERR_WORD  = 32'h741C507C;
    localparam logic [31:0] C_ZERO_WORD = 32'h3F3F3F3F;

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_ISSUE = 2'd1;
    localparam logic [1:0] C_WAIT  = 2'd2;
    localparam logic [1:0] C_LATCH = 2'd3;

    logic [1:0]          state_q, state_d;
    logic                last_b_q, last_b_d;
    logic                grant_b_q, grant_b_d;
    logic                err_q, err_d;
    logic [13:0]         conv_num_q, conv_num_d;
    logic [C_WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                done_q, done_d;
    logic                abort_q, abort_d;
    logic [31:0]         shown_q, shown_d;
    logic [C_SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]          idx_q, idx_d;
    logic [3:0]          an_q, an_d;
    logic [7:0]          seg_q, seg_d;

    logic                w_any_valid;
    logic                w_pick_b;
    logic                w_done_edge;
    logic                w_timeout;
    logic [7:0]          w_digit;
    logic [7:0]          w_disp;

    // B wins only when A is idle or A was served last
    assign w_any_valid = bus.req_a_valid | bus.req_b_valid;
    assign w_pick_b    = bus.req_b_valid & (~bus.req_a_valid | ~last_b_q);
    assign w_done_edge = bus.conv_done & ~done_q;
    assign w_timeout   = (wait_cnt_q == C_WAIT_LAST);
    assign w_digit     = shown_q[{idx_q, 3'b000} +: 8];

`ifdef BLANK_LEADING_ZERO_EN
    logic       shown_err_q, shown_err_d;
    logic [3:0] w_blank;

    always_comb begin
        w_blank    = 4'b0000;
        w_blank[3] = ~shown_err_q & (shown_q[31:24] == 8'h3F);
        w_blank[2] = w_blank[3] & (shown_q[23:16] == 8'h3F);
        w_blank[1] = w_blank[2] & (shown_q[15:8] == 8'h3F);
        w_disp     = w_blank[idx_q] ? 8'h00 : w_digit;
    end
`else
    assign w_disp = w_digit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= C_IDLE;
            last_b_q   <= 1'b1;
            grant_b_q  <= 1'b0;
            err_q      <= 1'b0;
            conv_num_q <= '0;
            wait_cnt_q <= '0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            shown_q    <= C_ZERO_WORD;
            scan_cnt_q <= '0;
            idx_q      <= 2'd0;
            an_q       <= 4'b1110;
            seg_q      <= 8'h3F;
`ifdef BLANK_LEADING_ZERO_EN
            shown_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            grant_b_q  <= grant_b_d;
            err_q      <= err_d;
            conv_num_q <= conv_num_d;
            wait_cnt_q <= wait_cnt_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            shown_q    <= shown_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
`ifdef BLANK_LEADING_ZERO_EN
            shown_err_q <= shown_err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE:  if (w_any_valid) state_d = C_ISSUE;
            C_ISSUE: state_d = C_WAIT;
            C_WAIT:  if (w_done_edge || w_timeout) state_d = C_LATCH;
            C_LATCH: state_d = C_IDLE;
            default: state_d = C_IDLE;
        endcase
    end

    always_comb begin
        last_b_d   = last_b_q;
        grant_b_d  = grant_b_q;
        err_d      = err_q;
        conv_num_d = conv_num_q;
        wait_cnt_d = wait_cnt_q;
        done_d     = done_q;
        abort_d    = abort_q;
        shown_d    = shown_q;
`ifdef BLANK_LEADING_ZERO_EN
        shown_err_d = shown_err_q;
`endif
        case (state_q)
            C_IDLE: begin
                if (w_any_valid) begin
                    last_b_d   = w_pick_b;
                    grant_b_d  = w_pick_b;
                    conv_num_d = w_pick_b ? bus.req_b_num : bus.req_a_num;
                    err_d      = w_pick_b ? bus.req_b_err : bus.req_a_err;
                end
            end
            C_ISSUE: begin
                wait_cnt_d = '0;
                done_d     = bus.conv_done;
            end
            C_WAIT: begin
                done_d     = bus.conv_done;
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (w_done_edge)    abort_d = 1'b0;
                else if (w_timeout) abort_d = 1'b1;
            end
            C_LATCH: begin
                shown_d = abort_q ? C_ERR_WORD : bus.conv_digits;
`ifdef BLANK_LEADING_ZERO_EN
                shown_err_d = abort_q | err_q;
`endif
            end
            default: ;
        endcase
    end

    // Display scan is free-running and independent of the sequencer
    always_comb begin
        scan_cnt_d = (scan_cnt_q == C_SCAN_LAST) ? '0 : scan_cnt_q + 1'b1;
        idx_d      = (scan_cnt_q == C_SCAN_LAST) ? idx_q + 2'd1 : idx_q;
        an_d       = ~(4'b0001 << idx_q);
        seg_d      = w_disp;
    end

    always_comb begin
        bus.req_a_ack  = 1'b0;
        bus.req_b_ack  = 1'b0;
        bus.conv_start = 1'b0;
        bus.conv_error = 1'b0;
        if (state_q == C_ISSUE) begin
            bus.req_a_ack  = ~grant_b_q;
            bus.req_b_ack  = grant_b_q;
            bus.conv_start = ~err_q;
            bus.conv_error = err_q;
        end
    end

    assign bus.conv_num = conv_num_q;
    assign busy         = (state_q != C_IDLE);
    assign an           = an_q;
    assign seg          = seg_q;
endmodule
`default_nettype wire

// File: tb/tb_seg_conv_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_conv_sched
// Description : Self-checking bench with a behavioural converter and a grant
//               scoreboard for seg_conv_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_conv_sched;
    localparam int SCAN_DIV = 4;
    localparam int TIMEOUT  = 24;
    localparam int LAT      = 5;
    localparam logic [31:0] ERRW = 32'h741C507C;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] seg;
    logic [3:0] an;
    logic       busy;

    seg_conv_sched_if ifc();

    seg_conv_sched #(.SCAN_DIV(SCAN_DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc),
        .seg (seg),
        .an  (an),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit conv_en = 1'b1;

    typedef struct { logic is_b; logic [13:0] num; logic err; } grant_t;
    grant_t exp_q[$];

    typedef struct {
        logic av; logic [13:0] anum; logic ae;
        logic bv; logic [13:0] bnum; logic be;
        logic first_b; logic [31:0] exp_word; logic exp_err;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] seg7(input int d);
        case (d)
            0: return 8'h3F; 1: return 8'h06; 2: return 8'h5B; 3: return 8'h4F;
            4: return 8'h66; 5: return 8'h6D; 6: return 8'h7D; 7: return 8'h07;
            8: return 8'h7F; 9: return 8'h6F; default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] enc(input logic [13:0] num);
        logic [31:0] w = '0;
        int n = int'(num);
        for (int i = 0; i < 4; i++) begin
            w[i*8 +: 8] = seg7(n % 10);
            n = n / 10;
        end
        return w;
    endfunction

    function automatic logic [31:0] disp(input logic [31:0] w, input logic e);
        logic [31:0] r = w;
`ifdef BLANK_LEADING_ZERO_EN
        if (!e) begin
            for (int i = 3; i >= 1; i--) begin
                if (r[i*8 +: 8] == 8'h3F) r[i*8 +: 8] = 8'h00;
                else break;
            end
        end
`else
        if (e) r = w;
`endif
        return r;
    endfunction

    // Behavioural converter: answers a strobe after LAT cycles
    initial begin
        logic [31:0] w;
        ifc.conv_done   = 1'b0;
        ifc.conv_digits = '0;
        forever begin
            @(posedge clk); #1;
            if (conv_en && (ifc.conv_start || ifc.conv_error)) begin
                w = ifc.conv_error ? ERRW : enc(ifc.conv_num);
                repeat (LAT) @(posedge clk);
                #1;
                ifc.conv_digits = w;
                ifc.conv_done   = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                ifc.conv_done = 1'b0;
            end
        end
    end

    task automatic read_display(output logic [31:0] w);
        w = 'x;
        for (int k = 0; k < 4 * SCAN_DIV; k++) begin
            @(negedge clk);
            case (an)
                4'b1110: w[7:0]   = seg;
                4'b1101: w[15:8]  = seg;
                4'b1011: w[23:16] = seg;
                4'b0111: w[31:24] = seg;
                default: w = 'x;
            endcase
        end
    endtask

    task automatic check_display(input string name, input logic [31:0] word, input logic e);
        logic [31:0] got;
        repeat (2) @(negedge clk);
        read_display(got);
        check(name, got, disp(word, e));
    endtask

    task automatic serve();
        grant_t g;
        bit fin = 1'b0;
        for (int c = 0; c < 600 && !fin; c++) begin
            @(negedge clk);
            if (ifc.req_a_ack || ifc.req_b_ack) begin
                if (exp_q.size() == 0) begin
                    check("spurious_ack", {ifc.req_a_ack, ifc.req_b_ack}, 2'b00);
                end else begin
                    g = exp_q.pop_front();
                    check("ack_who", {ifc.req_a_ack, ifc.req_b_ack}, g.is_b ? 2'b01 : 2'b10);
                    check("conv_num", ifc.conv_num, g.num);
                    check("strobe", {ifc.conv_start, ifc.conv_error}, g.err ? 2'b01 : 2'b10);
                end
                if (ifc.req_b_ack) ifc.req_b_valid = 1'b0;
                if (ifc.req_a_ack) ifc.req_a_valid = 1'b0;
            end
            if (exp_q.size() == 0 && !busy && !ifc.req_a_valid && !ifc.req_b_valid) fin = 1'b1;
        end
        check("serve_bound", fin, 1'b1);
    endtask

    initial begin
        logic [3:0] prev;
        int c;
        bit quiet;

        vecs[0] = '{1, 14'd5,    0, 1, 14'd7,    0, 1, 32'h3F3F3F6D, 0};
        vecs[1] = '{0, 14'd0,    0, 1, 14'd100,  0, 1, 32'h3F063F3F, 0};
        vecs[2] = '{1, 14'd8,    0, 1, 14'd3,    0, 0, 32'h3F3F3F4F, 0};
        vecs[3] = '{1, 14'd9999, 0, 1, 14'd12,   1, 0, ERRW,         1};
        vecs[4] = '{1, 14'd0,    0, 0, 14'd0,    0, 0, 32'h3F3F3F3F, 0};
        vecs[5] = '{1, 14'd42,   1, 1, 14'd1000, 0, 1, ERRW,         1};
        vecs[6] = '{0, 14'd0,    0, 1, 14'd42,   0, 1, 32'h3F3F665B, 0};
        vecs[7] = '{1, 14'd2004, 0, 0, 14'd0,    0, 0, 32'h5B3F3F66, 0};

        ifc.req_a_valid = 1'b0; ifc.req_a_num = '0; ifc.req_a_err = 1'b0;
        ifc.req_b_valid = 1'b0; ifc.req_b_num = '0; ifc.req_b_err = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_an", an, 4'b1110);
        check("rst_seg", seg, 8'h3F);
        check("rst_busy", busy, 1'b0);
        check("rst_acks", {ifc.req_a_ack, ifc.req_b_ack}, 2'b00);
        check("rst_strobes", {ifc.conv_start, ifc.conv_error}, 2'b00);
        rst = 1'b0;
        check_display("rst_display", 32'h3F3F3F3F, 1'b0);

        // Single A request: exact grant/strobe/latch timing
        ifc.req_a_valid = 1'b1; ifc.req_a_num = 14'd1234; ifc.req_a_err = 1'b0;
        @(negedge clk);
        check("lat_ack", {ifc.req_a_ack, ifc.req_b_ack}, 2'b10);
        check("lat_start", {ifc.conv_start, ifc.conv_error}, 2'b10);
        ifc.req_a_valid = 1'b0;
        @(negedge clk);
        check("lat_start_1cyc", ifc.conv_start, 1'b0);
        c = 0;
        while (!ifc.conv_done && c < 50) begin @(negedge clk); c++; end
        check("lat_done_seen", ifc.conv_done, 1'b1);
        @(negedge clk);
        check("lat_latch_busy", busy, 1'b1);
        @(negedge clk);
        check("lat_idle_busy", busy, 1'b0);
        check_display("lat_display", 32'h065B4F66, 1'b0);

        // Table of request patterns through the scoreboard
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            ifc.req_a_valid = vecs[v].av; ifc.req_a_num = vecs[v].anum; ifc.req_a_err = vecs[v].ae;
            ifc.req_b_valid = vecs[v].bv; ifc.req_b_num = vecs[v].bnum; ifc.req_b_err = vecs[v].be;
            if (vecs[v].av && vecs[v].bv) begin
                if (vecs[v].first_b) begin
                    exp_q.push_back('{1'b1, vecs[v].bnum, vecs[v].be});
                    exp_q.push_back('{1'b0, vecs[v].anum, vecs[v].ae});
                end else begin
                    exp_q.push_back('{1'b0, vecs[v].anum, vecs[v].ae});
                    exp_q.push_back('{1'b1, vecs[v].bnum, vecs[v].be});
                end
            end else if (vecs[v].bv) begin
                exp_q.push_back('{1'b1, vecs[v].bnum, vecs[v].be});
            end else begin
                exp_q.push_back('{1'b0, vecs[v].anum, vecs[v].ae});
            end
            serve();
            check_display("vec_display", vecs[v].exp_word, vecs[v].exp_err);
        end

        // Converter never answers: abort after TIMEOUT cycles in WAIT
        conv_en = 1'b0;
        @(negedge clk);
        ifc.req_a_valid = 1'b1; ifc.req_a_num = 14'd77; ifc.req_a_err = 1'b0;
        @(negedge clk);
        check("to_ack", ifc.req_a_ack, 1'b1);
        ifc.req_a_valid = 1'b0;
        c = 0;
        do begin @(negedge clk); c++; end while (busy && c < 200);
        check("to_cycles", c, TIMEOUT + 2);
        check_display("to_display", ERRW, 1'b1);
        conv_en = 1'b1;

        // Reset in the middle of a conversion
        ifc.req_a_valid = 1'b1; ifc.req_a_num = 14'd3333; ifc.req_a_err = 1'b0;
        @(negedge clk);
        check("rm_ack", ifc.req_a_ack, 1'b1);
        ifc.req_a_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (busy || ifc.req_a_ack || ifc.req_b_ack || ifc.conv_start || ifc.conv_error) quiet = 1'b0;
        end
        check("rm_quiet", quiet, 1'b1);
        check_display("rm_display", 32'h3F3F3F3F, 1'b0);

        // Scan period and anode rotation
        prev = an; c = 0;
        do begin @(negedge clk); c++; end while (an == prev && c < 2 * SCAN_DIV);
        for (int s = 0; s < 4; s++) begin
            prev = an; c = 0;
            do begin @(negedge clk); c++; end while (an == prev && c < 3 * SCAN_DIV);
            check("scan_period", c, SCAN_DIV);
            check("scan_rotate", an, {prev[2:0], prev[3]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
